// File: rtl/key_led_ctrl.sv
// key_led_ctrl: debounces four active-low keys into press pulses and runs the
// DIRECT/RUN/BLINK/HOLD LED mode machine.
module key_led_ctrl #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    output logic [3:0] led_out,
    output logic [1:0] mode,
    output logic [3:0] key_press
);
    localparam int DB_CNT = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int DW     = $clog2(DB_CNT);
    localparam int CW     = $clog2(STEP_CYCLES);

    typedef enum logic [1:0] {DIRECT, RUN, BLINK, HOLD} state_t;

    logic [3:0]    r_sync1, r_sync2, r_stable, r_press;
    logic [DW-1:0] r_db [4];
    logic [3:0]    w_flip;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_led, w_led_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_last;
    logic          r_paused, w_paused_nxt;
    logic [1:0]    r_speed;
    logic          w_run_blink, w_tick;

    always_comb begin
        for (int i = 0; i < 4; i++)
            w_flip[i] = (r_sync2[i] != r_stable[i]) && (r_db[i] == DW'(DB_CNT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_press  <= '0;
            r_db     <= '{default: '0};
        end else begin
            r_sync1  <= ~key_in;
            r_sync2  <= r_sync1;
            r_stable <= r_stable ^ w_flip;
            r_press  <= w_flip & ~r_stable;
            for (int i = 0; i < 4; i++)
                r_db[i] <= (r_sync2[i] == r_stable[i] || w_flip[i]) ? '0 : r_db[i] + DW'(1);
        end
    end

    assign w_run_blink = (r_state == RUN) || (r_state == BLINK);
    assign w_last      = CW'((STEP_CYCLES >> r_speed) - 1);
    assign w_tick      = w_run_blink && !r_paused && (r_cnt == w_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= DIRECT;
            r_led    <= '0;
            r_cnt    <= '0;
            r_paused <= 1'b0;
            r_speed  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_led    <= w_led_nxt;
            r_cnt    <= w_cnt_nxt;
            r_paused <= w_paused_nxt;
            r_speed  <= r_speed + {1'b0, r_press[2]};
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_led_nxt    = r_led;
        w_cnt_nxt    = r_cnt;
        w_paused_nxt = r_paused;
        if (r_press[0]) begin
            w_state_nxt  = state_t'(r_state + 2'd1);
            w_cnt_nxt    = '0;
            w_paused_nxt = 1'b0;
            w_led_nxt    = (w_state_nxt == RUN)    ? 4'b0001 :
                           (w_state_nxt == BLINK)  ? 4'b1111 :
                           (w_state_nxt == DIRECT) ? r_stable : r_led;
        end else begin
            if (w_run_blink && r_press[1])
                w_paused_nxt = !r_paused;
            // restart discards any tick landing on the same edge
            if (w_run_blink && r_press[3]) begin
                w_led_nxt = (r_state == RUN) ? 4'b0001 : 4'b1111;
                w_cnt_nxt = '0;
            end else begin
                if (w_run_blink && !r_paused)
                    w_cnt_nxt = w_tick ? '0 : r_cnt + CW'(1);
                if (w_tick)
                    w_led_nxt = (r_state == RUN) ? {r_led[2:0], r_led[3]} : ~r_led;
                if (r_state == DIRECT)
                    w_led_nxt = r_stable;
            end
            if (r_press[2])
                w_cnt_nxt = '0;
        end
    end

    assign led_out   = r_led;
    assign mode      = r_state;
    assign key_press = r_press;
endmodule

// File: tb/tb_key_led_ctrl.sv
// tb_key_led_ctrl: directed scoreboard bench for key_led_ctrl with
// DB_CNT = 4 and an 8-cycle base step period.
module tb_key_led_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_in = 4'hF;
    logic [3:0] led_out, key_press;
    logic [1:0] mode;

    key_led_ctrl #(.CLK_FREQ(1000), .DEBOUNCE_MS(4), .STEP_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .led_out(led_out), .mode(mode), .key_press(key_press)
    );

    always #5 clk = ~clk;

    string      q_tag[$];
    logic [3:0] q_exp[$];
    int         n_cmp = 0, n_fail = 0;
    logic [3:0] press_acc = '0, exp_led = '0;
    int         m = 0, spd = 0;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            press_acc |= key_press;
        end
    endtask

    task automatic push(input string tag, input logic [3:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic check(input logic [3:0] obs);
        string      t;
        logic [3:0] e;
        n_cmp++;
        if (q_exp.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %b with no expectation", obs);
            return;
        end
        t = q_tag.pop_front();
        e = q_exp.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", t, obs, e);
        end
    endtask

    // key held low 6 cycles to the pulse, one more for the FSM edge, then released
    task automatic press(input int k);
        key_in[k] = 1'b0;
        push($sformatf("press_pulse_k%0d", k), 4'(1 << k));
        tick(6);
        check(key_press);
        tick(1);
        key_in[k] = 1'b1;
    endtask

    task automatic run_steps(input int rem, input int n);
        int r = rem;
        for (int i = 0; i < n; i++) begin
            push("step_hold", exp_led);
            tick(r - 1);
            check(led_out);
            exp_led = (m == 1) ? {exp_led[2:0], exp_led[3]} : ~exp_led;
            push("step_next", exp_led);
            tick(1);
            check(led_out);
            r = 8 >> spd;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        push("rst_led", 4'h0); push("rst_mode", 4'h0); push("rst_press", 4'h0);
        tick(2);
        check(led_out); check({2'b00, mode}); check(key_press);
        rst = 1'b0;

        // bounce shorter than the debounce window
        press_acc = '0;
        push("bounce_press", 4'h0); push("bounce_mode", 4'h0);
        key_in = 4'hE; tick(3);
        key_in = 4'hF; tick(2);
        key_in = 4'hE; tick(3);
        key_in = 4'hF; tick(10);
        check(press_acc); check({2'b00, mode});

        // clean press of key0, held 10 cycles
        key_in = 4'hE;
        push("pulse_early", 4'h0);
        tick(5); check(key_press);
        push("pulse_edge6", 4'h1);
        tick(1); check(key_press);
        push("pulse_gone", 4'h0); push("mode_run", 4'h1); push("run_entry", 4'h1);
        tick(1); check(key_press); check({2'b00, mode}); check(led_out);
        m = 1; exp_led = 4'b0001;
        tick(3); key_in = 4'hF;

        // RUN at base period, counter is at 3 here
        run_steps(5, 4);

        // faster period after one key2
        press(2); spd = 1;
        run_steps(4, 4);

        // three more key2 wrap speed to 0; key3 restarts the pattern
        press(2); tick(8);
        press(2); tick(8);
        press(2); spd = 0;
        press(3); exp_led = 4'b0001;
        run_steps(8, 2);

        // pause at 0100, restart while paused, resume
        press(1);
        push("paused_hold", 4'b0100);
        tick(30); check(led_out);
        press(3);
        push("restart_paused", 4'b0001);
        check(led_out);
        push("restart_frozen", 4'b0001);
        tick(10); check(led_out);
        exp_led = 4'b0001;
        press(1);
        run_steps(8, 1);

        // mode cycle: BLINK, HOLD, DIRECT
        press(0); m = 2; exp_led = 4'b1111;
        push("mode_blink", 4'h2); push("blink_entry", 4'hF);
        check({2'b00, mode}); check(led_out);
        run_steps(8, 2);
        press(0); m = 3;
        push("mode_hold", 4'h3); push("hold_entry", 4'hF);
        check({2'b00, mode}); check(led_out);
        push("hold_frozen", 4'hF); push("hold_mode", 4'h3);
        tick(20); check(led_out); check({2'b00, mode});
        press(0); m = 0;
        push("mode_direct", 4'h0); push("direct_entry", 4'b0001);
        check({2'b00, mode}); check(led_out);
        push("direct_release", 4'h0);
        tick(8); check(led_out);

        // DIRECT mirror of keys 1 and 3 (ignored as commands here)
        key_in = 4'b0101;
        push("direct_press_early", 4'h0);
        tick(5); check(key_press);
        push("direct_press_pulse", 4'b1010); push("direct_led_e6", 4'h0);
        tick(1); check(key_press); check(led_out);
        push("direct_led_e7", 4'b1010); push("direct_mode", 4'h0);
        tick(1); check(led_out); check({2'b00, mode});
        key_in = 4'hF;
        push("direct_led_clear", 4'h0);
        tick(8); check(led_out);

        // reset mid-RUN with key1 mid-debounce
        press(0); m = 1;
        push("run_again", 4'h1);
        check({2'b00, mode});
        tick(5);
        key_in = 4'b1101;
        tick(3);
        rst = 1'b1; key_in = 4'hF;
        push("mid_rst_led", 4'h0); push("mid_rst_mode", 4'h0); push("mid_rst_press", 4'h0);
        tick(1); check(led_out); check({2'b00, mode}); check(key_press);
        rst = 1'b0; press_acc = '0;
        push("post_rst_press", 4'h0); push("post_rst_mode", 4'h0); push("post_rst_led", 4'h0);
        tick(12); check(press_acc); check({2'b00, mode}); check(led_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
